// File: rtl/watch_ctrl.sv
// Setting controller for a watch counter: RUN/SET_HOUR/SET_MIN/SET_SEC FSM, edit registers, load strobe and ci prescaler.
// Optional decrement button is compiled in when WATCH_CTRL_DEC_EN is defined.
module watch_ctrl #(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
`ifdef WATCH_CTRL_DEC_EN
    input  logic       btn_dec,
`endif
    input  logic [4:0] hour_cur,
    input  logic [5:0] min_cur,
    input  logic [5:0] sec_cur,
    output logic       ld,
    output logic [4:0] hour_set,
    output logic [5:0] min_set,
    output logic [5:0] sec_set,
    output logic       ci,
    output logic [1:0] mode
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [4:0]    hour_nx;
    logic [5:0]    min_nx, sec_nx;
    logic          ld_nx, ci_nx;
    logic          inc_req, dec_req;

`ifdef WATCH_CTRL_DEC_EN
    // Simultaneous inc and dec cancel out.
    assign inc_req = btn_inc & ~btn_dec;
    assign dec_req = btn_dec & ~btn_inc;
`else
    assign inc_req = btn_inc;
    assign dec_req = 1'b0;
`endif

    // Out-of-range values (>= max) wrap to 0 on increment.
    function automatic logic [4:0] step5(input logic [4:0] v, input logic [4:0] max,
                                         input logic up, input logic down);
        if (up)   return (v >= max) ? 5'd0 : v + 5'd1;
        if (down) return (v == 5'd0) ? max : v - 5'd1;
        return v;
    endfunction

    function automatic logic [5:0] step6(input logic [5:0] v, input logic [5:0] max,
                                         input logic up, input logic down);
        if (up)   return (v >= max) ? 6'd0 : v + 6'd1;
        if (down) return (v == 6'd0) ? max : v - 6'd1;
        return v;
    endfunction

    always_comb begin
        state_nx = state;
        presc_nx = '0;
        ld_nx    = 1'b0;
        ci_nx    = 1'b0;
        hour_nx  = hour_set;
        min_nx   = min_set;
        sec_nx   = sec_set;
        // btn_mode always wins; edits apply only when no mode step is taken.
        case (state)
            RUN: begin
                if (btn_mode) begin
                    state_nx = SET_HOUR;
                    hour_nx  = hour_cur;
                    min_nx   = min_cur;
                    sec_nx   = sec_cur;
                end else if (presc == PRESC_MAX) begin
                    ci_nx = 1'b1;
                end else begin
                    presc_nx = presc + PW'(1);
                end
            end
            SET_HOUR: begin
                if (btn_mode) state_nx = SET_MIN;
                else          hour_nx  = step5(hour_set, 5'd23, inc_req, dec_req);
            end
            SET_MIN: begin
                if (btn_mode) state_nx = SET_SEC;
                else          min_nx   = step6(min_set, 6'd59, inc_req, dec_req);
            end
            SET_SEC: begin
                if (btn_mode) begin
                    state_nx = RUN;
                    ld_nx    = 1'b1;
                end else begin
                    sec_nx = step6(sec_set, 6'd59, inc_req, dec_req);
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            ld       <= 1'b0;
            ci       <= 1'b0;
            hour_set <= '0;
            min_set  <= '0;
            sec_set  <= '0;
        end else begin
            presc    <= presc_nx;
            ld       <= ld_nx;
            ci       <= ci_nx;
            hour_set <= hour_nx;
            min_set  <= min_nx;
            sec_set  <= sec_nx;
        end
    end

    assign mode = state;

endmodule

// File: doc/watch_ctrl.md
WATCH_CTRL -- requirements
Module: watch_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 4, meaning the number of clk cycles per ci pulse in RUN, legal range 2..2^26.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port btn_mode, input, 1 bit, single-cycle pulse (pre-debounced) advancing the setting mode.
REQ-005 The block SHALL have port btn_inc, input, 1 bit, single-cycle pulse incrementing the selected field.
REQ-006 The block SHALL have ports hour_cur[4:0], min_cur[5:0], sec_cur[5:0], inputs, the watch counter's current time.
REQ-007 The block SHALL have port ld, output, 1 bit, load strobe to the watch counter.
REQ-008 The block SHALL have ports hour_set[4:0], min_set[5:0], sec_set[5:0], outputs, edit registers driven to the counter's load inputs.
REQ-009 The block SHALL have port ci, output, 1 bit, count-enable pulse to the watch counter.
REQ-010 The block SHALL have port mode[1:0], output, current state encoding for display: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.

Function
REQ-011 All outputs SHALL be registered.
REQ-012 The FSM SHALL have states RUN, SET_HOUR, SET_MIN, SET_SEC; btn_mode moves RUN->SET_HOUR->SET_MIN->SET_SEC->RUN, one step per pulse.
REQ-013 On RUN->SET_HOUR, the edit registers SHALL capture hour_cur/min_cur/sec_cur in the same edge.
REQ-014 btn_inc in SET_HOUR SHALL increment hour_set with wrap 23->0; in SET_MIN min_set 59->0; in SET_SEC sec_set 59->0; no carry between fields.
REQ-015 btn_inc in RUN SHALL be ignored.
REQ-016 btn_mode and btn_inc asserted in the same cycle: mode transition SHALL be taken, increment SHALL be discarded.
REQ-017 On SET_SEC->RUN, ld SHALL be 1 for exactly one cycle, the cycle after the btn_mode edge, with hour_set/min_set/sec_set stable.
REQ-018 In RUN a prescaler SHALL count 0..DIV-1; ci SHALL be 1 for one cycle each time the prescaler wraps, i.e. one pulse per DIV cycles.
REQ-019 In any SET state ci SHALL be 0 and the prescaler SHALL be held at 0; the first ci after ld SHALL occur DIV cycles after the ld cycle.
REQ-020 ld and ci SHALL never be 1 in the same cycle.
REQ-021 Out-of-range captured values (hour>23, min/sec>59) SHALL wrap to 0 on the next increment of that field.

Reset
REQ-022 While rst=0: state RUN, mode=0, ld=0, ci=0, prescaler=0, hour_set=min_set=sec_set=0.
REQ-023 Reset asserted in any SET state SHALL abandon the edit with no ld pulse.
REQ-024 After rst deasserts, the first ci SHALL occur DIV cycles later.

Configuration
REQ-025 With macro WATCH_CTRL_DEC_EN defined, the block SHALL add input btn_dec (1 bit pulse) decrementing the selected field with wrap 0->23 (hour) or 0->59 (min/sec); btn_inc and btn_dec together SHALL leave the field unchanged; btn_mode still has priority.
REQ-026 Without WATCH_CTRL_DEC_EN, port btn_dec and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset release, DIV=4, stay in RUN 40 cycles -> ci pulses at cycles 4,8,..., 10 pulses, ld=0 throughout.
REQ-028 cur=11:20:57, btn_mode x1 -> mode=1, set=11:20:57, ci=0; btn_inc x13 -> hour_set=0 (wrap at 23).
REQ-029 Enter SET_MIN with min_set=59, btn_inc -> min_set=0, hour_set unchanged; SET_SEC sec_set=59, btn_inc -> 0.
REQ-030 From SET_SEC with set=23:59:57, btn_mode -> ld=1 one cycle with 23:59:57, mode=0, next ci 4 cycles after ld.
REQ-031 btn_mode and btn_inc same cycle in SET_HOUR -> mode=2, hour_set unchanged.
REQ-032 rst=0 during SET_MIN -> mode=0, set regs 0, no ld; with WATCH_CTRL_DEC_EN, SET_HOUR hour_set=0 plus btn_dec -> 23.
